// File: rtl/mem_stage_ctrl.sv
// ============================================================================
// Module   : mem_stage_ctrl
// Brief    : MEM-stage controller. It resolves the branch, runs loads and
//            stores over a req/ack data-memory handshake with a timeout,
//            stalls upstream and drives the registered MEM/WB outputs.
//            Optional macro MEM_ALIGN_CHECK_EN rejects misaligned accesses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage_ctrl #(
  parameter int DATA_W         = 32,
  parameter int REG_W          = 5,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        in_M,
  input  logic [1:0]        in_WB,
  input  logic [DATA_W-1:0] in_add,
  input  logic              in_flag,
  input  logic [DATA_W-1:0] in_res,
  input  logic [DATA_W-1:0] in_dat2,
  input  logic [REG_W-1:0]  in_mux,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [DATA_W-1:0] ou_rdata,
  output logic [DATA_W-1:0] ou_res,
  output logic [REG_W-1:0]  ou_mux,
  output logic [1:0]        ou_WB,
  output logic              ou_pcsrc,
  output logic [DATA_W-1:0] ou_add,
  output logic              ou_err
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;

  // Instruction fields captured while the access is in flight
  logic [DATA_W-1:0]   res_q, res_d;
  logic [REG_W-1:0]    mux_q, mux_d;
  logic [1:0]          wb_q, wb_d;
  logic [DATA_W-1:0]   add_q, add_d;
  logic                pcsrc_q, pcsrc_d;

  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   ordata_q, ordata_d;
  logic [DATA_W-1:0]   ores_q, ores_d;
  logic [REG_W-1:0]    omux_q, omux_d;
  logic [1:0]          owb_q, owb_d;
  logic                opcsrc_q, opcsrc_d;
  logic [DATA_W-1:0]   oadd_q, oadd_d;
  logic                err_q, err_d;

  logic                w_memop;
  logic                w_misalign;
  logic                w_timeout_hit;

  assign w_memop = in_M[1] | in_M[0];

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misalign = |in_res[1:0];
`else
  assign w_misalign = 1'b0;
`endif

  assign w_timeout_hit = (state_q == BUSY) & ~dmem_ack & (cnt_q == c_TO_LAST);

  assign stall = ((state_q == IDLE) & w_memop & ~w_misalign) |
                 ((state_q == BUSY) & ~dmem_ack & ~w_timeout_hit);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    mux_d    = mux_q;
    wb_d     = wb_q;
    add_d    = add_q;
    pcsrc_d  = pcsrc_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ordata_d = ordata_q;
    ores_d   = ores_q;
    omux_d   = omux_q;
    owb_d    = owb_q;
    opcsrc_d = opcsrc_q;
    oadd_d   = oadd_q;
    err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (w_memop && w_misalign) begin
          owb_d    = 2'b00;
          opcsrc_d = 1'b0;
          err_d    = 1'b1;
        end else if (w_memop) begin
          // MemWrite wins when both MemRead and MemWrite are set
          state_d  = BUSY;
          cnt_d    = 8'd0;
          req_d    = 1'b1;
          we_d     = in_M[0];
          addr_d   = in_res;
          wdata_d  = in_dat2;
          res_d    = in_res;
          mux_d    = in_mux;
          wb_d     = in_WB;
          add_d    = in_add;
          pcsrc_d  = in_M[2] & in_flag;
          owb_d    = 2'b00;
          opcsrc_d = 1'b0;
        end else begin
          ores_d   = in_res;
          omux_d   = in_mux;
          owb_d    = in_WB;
          oadd_d   = in_add;
          opcsrc_d = in_M[2] & in_flag;
        end
      end
      BUSY: begin
        if (dmem_ack) begin
          state_d  = IDLE;
          req_d    = 1'b0;
          if (!we_q) begin
            ordata_d = dmem_rdata;
          end
          ores_d   = res_q;
          omux_d   = mux_q;
          owb_d    = wb_q;
          oadd_d   = add_q;
          opcsrc_d = pcsrc_q;
        end else if (w_timeout_hit) begin
          state_d  = IDLE;
          req_d    = 1'b0;
          owb_d    = 2'b00;
          opcsrc_d = 1'b0;
          err_d    = 1'b1;
        end else begin
          cnt_d    = cnt_q + 8'd1;
          owb_d    = 2'b00;
          opcsrc_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      res_q    <= '0;
      mux_q    <= '0;
      wb_q     <= '0;
      add_q    <= '0;
      pcsrc_q  <= 1'b0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ordata_q <= '0;
      ores_q   <= '0;
      omux_q   <= '0;
      owb_q    <= '0;
      opcsrc_q <= 1'b0;
      oadd_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      mux_q    <= mux_d;
      wb_q     <= wb_d;
      add_q    <= add_d;
      pcsrc_q  <= pcsrc_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ordata_q <= ordata_d;
      ores_q   <= ores_d;
      omux_q   <= omux_d;
      owb_q    <= owb_d;
      opcsrc_q <= opcsrc_d;
      oadd_q   <= oadd_d;
      err_q    <= err_d;
    end
  end

  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign ou_rdata   = ordata_q;
  assign ou_res     = ores_q;
  assign ou_mux     = omux_q;
  assign ou_WB      = owb_q;
  assign ou_pcsrc   = opcsrc_q;
  assign ou_add     = oadd_q;
  assign ou_err     = err_q;

endmodule

`default_nettype wire
